// File: rtl/i2s_sample_tx.sv
// Mono I2S transmitter: buffers 16-bit samples in a small FIFO and sends each one in both slots.
// Optional build macro UNDERFLOW_HOLD_EN: on underflow, repeat the last sample instead of sending silence.
module i2s_sample_tx #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned BCLK_DIV = 8,
  parameter int unsigned FIFO_AW  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             in_ready,
  input  logic             clr_flags,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             fifo_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH      = 2 ** FIFO_AW;
  localparam int unsigned FRAME_BITS = 2 * WIDTH;
  localparam int unsigned DIV_W      = $clog2(BCLK_DIV);
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
  localparam int unsigned CNT_W      = FIFO_AW + 1;

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  bclk_q, bclk_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  lrclk_q, lrclk_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];

  logic                  div_wrap_c;
  logic                  fall_c;
  logic                  load_c;
  logic                  empty_c;
  logic                  full_c;
  logic                  pop_ok_c;
  logic                  push_ok_c;
  logic                  ovf_set_c;
  logic                  udf_set_c;
  logic [WIDTH-1:0]      head_c;
  logic [WIDTH-1:0]      frame_sample_c;

`ifdef UNDERFLOW_HOLD_EN
  logic [WIDTH-1:0]      last_sample_q, last_sample_d;
`endif

  // Timing events: bclk falls on a divider wrap while high; a frame loads on the fall leaving bit 0.
  always_comb begin
    div_wrap_c = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    fall_c     = div_wrap_c && bclk_q;
    load_c     = fall_c && (bit_cnt_q == '0);
    empty_c    = (count_q == '0);
    full_c     = (count_q == CNT_W'(DEPTH));
    pop_ok_c   = load_c && !empty_c;
    push_ok_c  = in_ready && (!full_c || pop_ok_c);
    ovf_set_c  = in_ready && full_c && !pop_ok_c;
    udf_set_c  = load_c && empty_c;
    head_c     = mem_q[rd_ptr_q];
  end

  // Sample for the next frame: FIFO head, else silence or the held sample.
`ifdef UNDERFLOW_HOLD_EN
  assign frame_sample_c = pop_ok_c ? head_c : last_sample_q;
`else
  assign frame_sample_c = pop_ok_c ? head_c : '0;
`endif

  always_comb begin
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    shreg_d   = shreg_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    full_d    = full_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
`ifdef UNDERFLOW_HOLD_EN
    last_sample_d = last_sample_q;
`endif

    if (div_wrap_c) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    // Serial side advances only on bclk fall so the codec samples stable data on rise.
    if (fall_c) begin
      bit_cnt_d = (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
      lrclk_d   = (bit_cnt_d >= BIT_W'(WIDTH));
      if (load_c) begin
        shreg_d = {frame_sample_c, frame_sample_c};
      end else begin
        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
      end
    end

    if (push_ok_c) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
`ifdef UNDERFLOW_HOLD_EN
      last_sample_d = head_c;
`endif
    end
    count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
    full_d  = (count_d == CNT_W'(DEPTH));

    // Sticky flags: a set in the same cycle as a clear wins.
    if (ovf_set_c) begin
      ovf_d = 1'b1;
    end else if (clr_flags) begin
      ovf_d = 1'b0;
    end
    if (udf_set_c) begin
      udf_d = 1'b1;
    end else if (clr_flags) begin
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      lrclk_q   <= 1'b0;
      shreg_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      shreg_q   <= shreg_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

`ifdef UNDERFLOW_HOLD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_sample_q <= '0;
    end else begin
      last_sample_q <= last_sample_d;
    end
  end
`endif

  // Storage needs no reset: the count defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  assign bclk      = bclk_q;
  assign lrclk     = lrclk_q;
  assign sdata     = shreg_q[FRAME_BITS-1];
  assign fifo_full = full_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Scoreboard bench for i2s_sample_tx (WIDTH=16, BCLK_DIV=2, FIFO_AW=2, 128-clk frames).
module tb_i2s_sample_tx;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned BCLK_DIV = 2;
  localparam int unsigned FIFO_AW  = 2;
  localparam int          FRAME    = 128;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic [15:0] sample_in = '0;
  logic        in_ready  = 1'b0;
  logic        clr_flags = 1'b0;
  logic        bclk, lrclk, sdata, fifo_full, overflow, underflow;

  i2s_sample_tx #(.WIDTH(WIDTH), .BCLK_DIV(BCLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .in_ready(in_ready),
    .clr_flags(clr_flags), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .fifo_full(fifo_full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: clk edges since reset, FIFO queue, expected frames, sticky flags.
  int          edge_n = 0;
  logic [15:0] mq[$];
  logic [31:0] exp_frames[$];
  logic        m_uf = 1'b0;
  logic        m_ov = 1'b0;
  logic [15:0] m_last = '0;
  logic [15:0] m_s;
  logic        m_su, m_so;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_n = 0;
      mq.delete();
      exp_frames.delete();
      m_uf   = 1'b0;
      m_ov   = 1'b0;
      m_last = '0;
    end else begin
      edge_n++;
      m_su = 1'b0;
      m_so = 1'b0;
      if (edge_n >= 4 && ((edge_n - 4) % FRAME) == 0) begin
        if (mq.size() > 0) begin
          m_s    = mq.pop_front();
          m_last = m_s;
        end else begin
`ifdef UNDERFLOW_HOLD_EN
          m_s = m_last;
`else
          m_s = '0;
`endif
          m_su = 1'b1;
        end
        exp_frames.push_back({m_s, m_s});
      end
      if (in_ready) begin
        if (mq.size() < 4) mq.push_back(sample_in);
        else m_so = 1'b1;
      end
      if (m_su) m_uf = 1'b1; else if (clr_flags) m_uf = 1'b0;
      if (m_so) m_ov = 1'b1; else if (clr_flags) m_ov = 1'b0;
    end
  end

  // Monitor: flags every cycle; bclk level, lrclk and sdata capture at each bclk rise.
  int          r;
  logic [31:0] cap = '0;
  logic [31:0] f;

  always @(negedge clk) begin
    if (!reset) begin
      check("fifo_full", 32'(fifo_full), 32'(mq.size() == 4));
      check("overflow", 32'(overflow), 32'(m_ov));
      check("underflow", 32'(underflow), 32'(m_uf));
      if (edge_n % 4 == 2) begin
        r = edge_n / 4;
        check("bclk_hi", 32'(bclk), 32'd1);
        check("lrclk", 32'(lrclk), 32'((r % 32) >= 16));
        cap = {cap[30:0], sdata};
        if (r % 32 == 0 && r > 0) begin
          check("frame_avail", 32'(exp_frames.size()), 32'd1);
          if (exp_frames.size() > 0) begin
            f = exp_frames.pop_front();
            check("frame", cap, f);
          end
        end
      end else if (edge_n % 4 == 0) begin
        check("bclk_lo", 32'(bclk), 32'd0);
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_bclk"}, 32'(bclk), 32'd0);
    check({tag, "_lrclk"}, 32'(lrclk), 32'd0);
    check({tag, "_sdata"}, 32'(sdata), 32'd0);
    check({tag, "_full"}, 32'(fifo_full), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_udf"}, 32'(underflow), 32'd0);
  endtask

  task automatic push(input logic [15:0] s);
    sample_in = s;
    in_ready  = 1'b1;
    @(negedge clk);
    in_ready  = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((edge_n % FRAME) == p) begin
        hit = 1'b1;
        break;
      end
    end
    check("phase_wait", 32'(hit), 32'd1);
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  initial begin
    // Reset state, then idle frames that underflow with silent data.
    repeat (3) @(negedge clk);
    reset_checks("rst");
    #2 reset = 1'b0;
    wait_frames(2);

    // Single sample with a distinctive MSB and LSB.
    wait_phase(10);
    push(16'h8001);
    wait_frames(2);

    // Five back-to-back pushes: the fifth is dropped.
    wait_phase(10);
    for (int i = 1; i <= 5; i++) push(16'hA000 + 16'(i));
    wait_frames(5);

    // Full FIFO with a push on the load cycle, flag clears around it.
    wait_phase(10);
    for (int i = 1; i <= 4; i++) push(16'hB000 + 16'(i));
    wait_phase(20);
    pulse_clr();
    wait_phase(3);
    push(16'hB005);
    wait_phase(30);
    pulse_clr();
    wait_frames(6);

    // One sample then starvation: silence, or a repeat when holding.
    wait_phase(10);
    push(16'h1234);
    wait_frames(3);

    // Reset in the middle of a frame with two entries queued.
    wait_phase(10);
    push(16'hC001);
    push(16'hC002);
    wait_phase(81);
    #2 reset = 1'b1;
    @(negedge clk);
    reset_checks("midrst");
    @(negedge clk);
    #2 reset = 1'b0;
    wait_frames(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
